syn_asyn_reset: RTL and testbench

SYN_ASYN_RESET -- requirements
Module: syn_asyn_reset

---
 rtl/syn_asyn_reset_pkg.sv | 14 +
 rtl/syn_asyn_reset_if.sv | 13 +
 rtl/syn_asyn_reset_reset_sync.sv | 34 +++
 rtl/syn_asyn_reset.sv | 49 ++++
 tb/tb_syn_asyn_reset.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/syn_asyn_reset_pkg.sv
// Shared constants for the reset-demonstration block: synchronizer depth
// default, its legal range, and a helper used for elaboration-time checks.
package syn_asyn_reset_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // True when a requested synchronizer depth is usable.
  function automatic bit sync_stages_ok(input int n);
    return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
  endfunction

endpackage

// File: rtl/syn_asyn_reset_if.sv
// Bundle of the data-side signals of syn_asyn_reset. The block itself keeps
// plain positional ports (clk, rst, D, syn_q, asyn_q) so it drops into legacy
// netlists; this interface is how newer integration and benches carry them.
interface syn_asyn_reset_if;
  logic D;
  logic syn_q;
  logic asyn_q;

  // Driver of D, consumer of both registered copies.
  modport master (output D, input syn_q, input asyn_q);
  // The register block: consumes D, produces both copies.
  modport slave  (input D, output syn_q, output asyn_q);
endinterface

// File: rtl/syn_asyn_reset_reset_sync.sv
// Reset-release synchronizer: asserts asynchronously, releases only after
// STAGES rising edges with rst high, so the release is clean in the clk domain.
module reset_sync
  import syn_asyn_reset_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic rst_sync_n
);

  if (!sync_stages_ok(STAGES)) begin : g_bad_stages
    $error("reset_sync: STAGES=%0d outside legal range %0d..%0d",
           STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
  end

  logic [STAGES-1:0] s_q;
  logic [STAGES-1:0] s_d;

  // Shift a constant 1 in from the bottom; chain fills after STAGES edges.
  always_comb begin
    s_d = {s_q[STAGES-2:0], 1'b1};
  end

  // Chain clears the instant rst drops, independent of clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s_q <= '0;
    else      s_q <= s_d;
  end

  assign rst_sync_n = s_q[STAGES-1];

endmodule

// File: rtl/syn_asyn_reset.sv
// Two registered copies of D side by side: asyn_q is cleared directly by rst,
// syn_q is cleared only through the synchronized reset, on clock edges.
module syn_asyn_reset
  import syn_asyn_reset_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic D,
  output logic syn_q,
  output logic asyn_q
);

  if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_stages
    $error("syn_asyn_reset: SYNC_STAGES=%0d outside legal range %0d..%0d",
           SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
  end

  logic rst_sync_n;
  logic asyn_d;
  logic syn_d;

  reset_sync #(
    .STAGES (SYNC_STAGES)
  ) u_reset_sync (
    .clk        (clk),
    .rst        (rst),
    .rst_sync_n (rst_sync_n)
  );

  // Next values: asyn path takes D directly, syn path is gated by rst_sync_n.
  always_comb begin
    asyn_d = D;
    syn_d  = rst_sync_n ? D : 1'b0;
  end

  // Async-cleared copy: drops to 0 the moment rst falls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) asyn_q <= 1'b0;
    else      asyn_q <= asyn_d;
  end

  // Sync-cleared copy: no async clear, so it only changes on clk edges.
  always_ff @(posedge clk) begin
    syn_q <= syn_d;
  end

endmodule

// File: tb/tb_syn_asyn_reset.sv
// Scoreboard bench for syn_asyn_reset (SYNC_STAGES=2, clk period 10).
module tb_syn_asyn_reset;
  localparam int SYNC = 2;

  typedef struct {
    string name;
    logic  es;    // expected syn_q
    logic  ea;    // expected asyn_q
    bit    cs;    // compare syn_q (0 where it is legitimately racy)
  } exp_t;

  logic clk;
  logic rst;
  syn_asyn_reset_if u_if ();

  syn_asyn_reset #(.SYNC_STAGES(SYNC)) dut (
    .clk    (clk),
    .rst    (rst),
    .D      (u_if.D),
    .syn_q  (u_if.syn_q),
    .asyn_q (u_if.asyn_q)
  );

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: count edges seen with rst high since the last assertion.
  int   rel_cnt;
  logic m_asyn;
  logic m_syn;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rel_cnt <= 0;
      m_asyn  <= 1'b0;
    end else begin
      rel_cnt <= (rel_cnt < SYNC) ? rel_cnt + 1 : rel_cnt;
      m_asyn  <= u_if.D;
    end
  end
  always @(posedge clk) begin
    m_syn <= (rst && rel_cnt >= SYNC) ? u_if.D : 1'b0;
  end

  task automatic at_t(input int t);
    if (t > $time) #(t - $time);
  endtask

  task automatic push(input string name, input logic es, input logic ea, input bit cs);
    exp_t e;
    e.name = name; e.es = es; e.ea = ea; e.cs = cs;
    sb.push_back(e);
  endtask

  // Monitor: pops each expectation as it appears and compares live outputs.
  initial begin
    exp_t e;
    forever begin
      wait (sb.size() != 0);
      e = sb.pop_front();
      checks++;
      if ((u_if.asyn_q !== e.ea) || (e.cs && (u_if.syn_q !== e.es))) begin
        errors++;
        $display("FAIL %s @%0t: got syn_q=%b asyn_q=%b, want syn_q=%b asyn_q=%b%s",
                 e.name, $time, u_if.syn_q, u_if.asyn_q, e.es, e.ea,
                 e.cs ? "" : " (syn_q not compared)");
      end
    end
  end

  initial begin
    rst = 1'b1; u_if.D = 1'b1;
    // Power-up: rst low before the first edge, D=1.
    at_t(1);   rst = 1'b0;
    at_t(2);   push("pwr_async_clear", 1'b0, 1'b0, 1'b0);
    at_t(6);   push("pwr_first_edge",  1'b0, 1'b0, 1'b1);
    // Release at t=12: asyn at 15, syn at 35.
    at_t(12);  rst = 1'b1;
    at_t(16);  push("rel_edge15", 1'b0, 1'b1, 1'b1);
    at_t(26);  push("rel_edge25", 1'b0, 1'b1, 1'b1);
    at_t(36);  push("rel_edge35", 1'b1, 1'b1, 1'b1);
    // Mid-cycle assert at t=52.
    at_t(46);  push("steady_both1", 1'b1, 1'b1, 1'b1);
    at_t(52);  rst = 1'b0;
    at_t(53);  push("mid_assert_async", 1'b1, 1'b0, 1'b1);
    at_t(56);  push("mid_assert_edge55", 1'b0, 1'b0, 1'b1);
    // D wiggles while in reset: no effect.
    at_t(57);  u_if.D = 1'b0;
    at_t(62);  u_if.D = 1'b1;
    at_t(66);  push("d_ignored_in_reset", 1'b0, 1'b0, 1'b1);
    // Second release at 72, then steady.
    at_t(72);  rst = 1'b1;
    at_t(76);  push("rel2_edge75", 1'b0, 1'b1, 1'b1);
    at_t(86);  push("rel2_edge85", 1'b0, 1'b1, 1'b1);
    at_t(96);  push("rel2_edge95", 1'b1, 1'b1, 1'b1);
    // Glitch: 2-unit low pulse between edges.
    at_t(97);  rst = 1'b0;
    at_t(98);  push("glitch_async", 1'b1, 1'b0, 1'b1);
    at_t(99);  rst = 1'b1;
    at_t(106); push("glitch_edge105", 1'b0, 1'b1, 1'b1);
    at_t(116); push("glitch_edge115", 1'b0, 1'b1, 1'b1);
    at_t(126); push("glitch_recover125", 1'b1, 1'b1, 1'b1);
    // Toggle D=0 then 1 with rst steady high.
    at_t(127); u_if.D = 1'b0;
    at_t(136); push("toggle_d0", 1'b0, 1'b0, 1'b1);
    at_t(137); u_if.D = 1'b1;
    at_t(146); push("toggle_d1", 1'b1, 1'b1, 1'b1);
    // Reassert during the release window.
    at_t(152); rst = 1'b0;
    at_t(156); push("rewin_assert", 1'b0, 1'b0, 1'b1);
    at_t(157); rst = 1'b1;
    at_t(166); push("rewin_first_edge", 1'b0, 1'b1, 1'b1);
    at_t(168); rst = 1'b0;
    at_t(169); push("rewin_reassert", 1'b0, 1'b0, 1'b1);
    at_t(176); push("rewin_edge175", 1'b0, 1'b0, 1'b1);
    at_t(177); rst = 1'b1;
    at_t(186); push("rewin_restart185", 1'b0, 1'b1, 1'b1);
    at_t(196); push("rewin_restart195", 1'b0, 1'b1, 1'b1);
    at_t(206); push("rewin_capture205", 1'b1, 1'b1, 1'b1);
    // rst falls exactly on the edge at t=215: asyn must end at 0.
    at_t(215); rst = 1'b0;
    at_t(216); push("same_step_reset", 1'b0, 1'b0, 1'b0);
    at_t(226); push("same_step_next_edge", 1'b0, 1'b0, 1'b1);
    // Periodic reset vs. reference model.
    fork
      begin
        for (int i = 0; i < 20; i++) begin at_t(232 + 15 * i); rst = ~rst; end
      end
      begin
        for (int i = 0; i < 29; i++) begin at_t(233 + 10 * i); u_if.D = ~u_if.D; end
      end
      begin
        for (int i = 0; i < 28; i++) begin
          at_t(240 + 10 * i);
          push($sformatf("periodic_%0d", i), m_syn, m_asyn, 1'b1);
        end
      end
    join
    // Drain the scoreboard with a bound.
    fork
      wait (sb.size() == 0);
      #100;
    join_any
    disable fork;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
